// File: rtl/bus_arbiter2.sv
// rtl/bus_arbiter2.sv - two-master round-robin arbiter for one shared valid/ready memory bus
// Optional slave-wait timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_dout,
    input  logic              m0_wr,
    input  logic [DW/8-1:0]   m0_lane,
    input  logic              m0_valid,
    output logic [DW-1:0]     m0_din,
    output logic              m0_ready,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_dout,
    input  logic              m1_wr,
    input  logic [DW/8-1:0]   m1_lane,
    input  logic              m1_valid,
    output logic [DW-1:0]     m1_din,
    output logic              m1_ready,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_dout,
    output logic              s_wr,
    output logic [DW/8-1:0]   s_lane,
    output logic              s_valid,
    input  logic [DW-1:0]     s_din,
    input  logic              s_ready,
    output logic              owner,
    output logic              timeout
);
    localparam int LW = DW / 8;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("bus_arbiter2: TIMEOUT must lie in 1..65535");
    end

    typedef enum logic [1:0] {IDLE, BUS, RESP, RECOVER} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  s_addr_q;
    logic [DW-1:0]  s_dout_q;
    logic           s_wr_q;
    logic [LW-1:0]  s_lane_q;
    logic [DW-1:0]  m0_din_q, m1_din_q;
    logic           owner_q;
    logic           last_q;

    logic [1:0]     req;
    logic           grant_idx;
    logic           do_grant;
    logic           done;
    logic           expire;
    logic [DW-1:0]  resp_data;

    // Ties go to the master that was not served last.
    assign req       = {m1_valid, m0_valid};
    assign grant_idx = (req == 2'b11) ? ~last_q : req[1];
    assign do_grant  = (state_q == IDLE) && (req != 2'b00);
    assign done      = (state_q == BUS) && (s_ready || expire);
    assign resp_data = s_ready ? s_din : '1;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        to_q;

    // A slave completing in the expiry cycle still wins over the abort.
    assign expire = (state_q == BUS) && !s_ready && (cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            if (do_grant) begin
                cnt_q <= '0;
            end else if (state_q == BUS && !s_ready) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (done) begin
                to_q <= expire;
            end
        end
    end

    assign timeout = (state_q == RESP) && to_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_grant) state_d = BUS;
            BUS:     if (done)     state_d = RESP;
            RESP:                  state_d = RECOVER;
            RECOVER:               state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        s_valid  = (state_q == BUS);
        m0_ready = (state_q == RESP) && !owner_q;
        m1_ready = (state_q == RESP) &&  owner_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_addr_q <= '0;
            s_dout_q <= '0;
            s_wr_q   <= 1'b0;
            s_lane_q <= '0;
            m0_din_q <= '0;
            m1_din_q <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            if (do_grant) begin
                owner_q  <= grant_idx;
                last_q   <= grant_idx;
                s_addr_q <= grant_idx ? m1_addr : m0_addr;
                s_dout_q <= grant_idx ? m1_dout : m0_dout;
                s_wr_q   <= grant_idx ? m1_wr   : m0_wr;
                s_lane_q <= grant_idx ? m1_lane : m0_lane;
            end
            // The non-owner's read data is left untouched.
            if (done) begin
                if (owner_q) begin
                    m1_din_q <= resp_data;
                end else begin
                    m0_din_q <= resp_data;
                end
            end
        end
    end

    assign s_addr = s_addr_q;
    assign s_dout = s_dout_q;
    assign s_wr   = s_wr_q;
    assign s_lane = s_lane_q;
    assign m0_din = m0_din_q;
    assign m1_din = m1_din_q;
    assign owner  = owner_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb/tb_bus_arbiter2.sv - self-checking bench for bus_arbiter2
module tb_bus_arbiter2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = DW / 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic          clk, rst;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_dout, m1_dout;
    logic          m0_wr, m1_wr;
    logic [LW-1:0] m0_lane, m1_lane;
    logic          m0_valid, m1_valid;
    logic [DW-1:0] m0_din, m1_din;
    logic          m0_ready, m1_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_dout;
    logic          s_wr;
    logic [LW-1:0] s_lane;
    logic          s_valid;
    logic [DW-1:0] s_din;
    logic          s_ready;
    logic          owner, timeout;

    int passed = 0;
    int total  = 0;

    // Reference model: who was served last, who is waiting, what each asked for.
    int            last;
    bit            pend   [2];
    logic [AW-1:0] addr_m [2];
    logic [DW-1:0] dout_m [2];
    logic          wr_m   [2];
    logic [LW-1:0] lane_m [2];
    logic [DW-1:0] din_m  [2];

    typedef struct {
        bit            r0, r1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        bit            w0, w1;
        logic [LW-1:0] l0, l1;
        int            wt;
        logic [DW-1:0] sd;
        int            eo;
        logic [AW-1:0] ea;
        bit            ew;
    } vec_t;

    bus_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_wr(m0_wr), .m0_lane(m0_lane),
        .m0_valid(m0_valid), .m0_din(m0_din), .m0_ready(m0_ready),
        .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_wr(m1_wr), .m1_lane(m1_lane),
        .m1_valid(m1_valid), .m1_din(m1_din), .m1_ready(m1_ready),
        .s_addr(s_addr), .s_dout(s_dout), .s_wr(s_wr), .s_lane(s_lane),
        .s_valid(s_valid), .s_din(s_din), .s_ready(s_ready),
        .owner(owner), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic vec_t mk(bit r0, bit r1, logic [AW-1:0] a0, logic [AW-1:0] a1,
                                logic [DW-1:0] d0, logic [DW-1:0] d1, bit w0, bit w1,
                                logic [LW-1:0] l0, logic [LW-1:0] l1, int wt,
                                logic [DW-1:0] sd, int eo, logic [AW-1:0] ea, bit ew);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1; v.wt = wt; v.sd = sd;
        v.eo = eo; v.ea = ea; v.ew = ew;
        return v;
    endfunction

    task automatic raise(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic w, input logic [LW-1:0] l);
        addr_m[idx] = a; dout_m[idx] = d; wr_m[idx] = w; lane_m[idx] = l; pend[idx] = 1'b1;
        if (idx == 0) begin
            m0_addr = a; m0_dout = d; m0_wr = w; m0_lane = l; m0_valid = 1'b1;
        end else begin
            m1_addr = a; m1_dout = d; m1_wr = w; m1_lane = l; m1_valid = 1'b1;
        end
    endtask

    function automatic logic rdy(input int idx);
        return (idx == 1) ? m1_ready : m0_ready;
    endfunction

    function automatic logic [DW-1:0] din_of(input int idx);
        return (idx == 1) ? m1_din : m0_din;
    endfunction

    // Plays the slave for one transaction and the owning master's handshake.
    task automatic serve(input int wait_n, input logic [DW-1:0] sdin,
                         output int got_owner, output logic [AW-1:0] got_addr, output logic got_wr);
        int w;
        int n;
        logic [AW-1:0] a;
        w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
        n = 0;
        while (s_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", 64'(s_valid), 64'(1));
        got_owner = int'(owner);
        got_addr  = s_addr;
        got_wr    = s_wr;
        chk("owner", 64'(owner), 64'(w));
        chk("s_addr", 64'(s_addr), 64'(addr_m[w]));
        chk("s_dout", 64'(s_dout), 64'(dout_m[w]));
        chk("s_wr", 64'(s_wr), 64'(wr_m[w]));
        chk("s_lane", 64'(s_lane), 64'(lane_m[w]));
        a = s_addr;
        for (int i = 0; i < wait_n; i++) begin
            if (w == 0) begin
                m0_addr = $urandom; m0_dout = $urandom;
            end else begin
                m1_addr = $urandom; m1_dout = $urandom;
            end
            @(negedge clk);
            chk("hold_addr", 64'(s_addr), 64'(a));
            chk("hold_valid", 64'(s_valid), 64'(1));
            chk("no_early_ready", 64'({m1_ready, m0_ready}), 64'(0));
        end
        s_ready = 1'b1;
        s_din   = sdin;
        @(negedge clk);
        s_ready = 1'b0;
        s_din   = $urandom;
        chk("ready_owner", 64'(rdy(w)), 64'(1));
        chk("ready_other", 64'(rdy(1 - w)), 64'(0));
        chk("din_owner", 64'(din_of(w)), 64'(sdin));
        chk("din_other", 64'(din_of(1 - w)), 64'(din_m[1 - w]));
        chk("s_valid_drop", 64'(s_valid), 64'(0));
        chk("no_timeout", 64'(timeout), 64'(0));
        @(negedge clk);
        chk("ready_pulse", 64'({m1_ready, m0_ready}), 64'(0));
        @(negedge clk);
        if (w == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
        last = w;
        pend[w] = 1'b0;
        din_m[w] = sdin;
    endtask

    initial begin
        int o;
        int n;
        logic [AW-1:0] ga;
        logic gw;
        vec_t vt [12];

        rst = 1'b1;
        m0_addr = '0; m0_dout = '0; m0_wr = 1'b0; m0_lane = '0; m0_valid = 1'b0;
        m1_addr = '0; m1_dout = '0; m1_wr = 1'b0; m1_lane = '0; m1_valid = 1'b0;
        s_din = '0; s_ready = 1'b0;
        last = 1; pend[0] = 1'b0; pend[1] = 1'b0; din_m[0] = '0; din_m[1] = '0;

        #1;
        chk("rst_s_valid", 64'(s_valid), 64'(0));
        chk("rst_ready", 64'({m1_ready, m0_ready}), 64'(0));
        chk("rst_owner", 64'(owner), 64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_s_bus", 64'({s_wr, s_lane, s_addr}), 64'(0));
        chk("rst_din", 64'({m1_din, m0_din}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        vt[0]  = mk(1, 1, 'h100, 'h203, 'h0, 'h55555555, 0, 1, 'hF, 'h8, 2, 'hDEADBEEF, 0, 'h100, 0);
        vt[1]  = mk(0, 0, 'h0,   'h0,   'h0, 'h0,        0, 0, 'h0, 'h0, 0, 'h12345678, 1, 'h203, 1);
        vt[2]  = mk(1, 1, 'h10,  'h20,  'h1, 'h2,        0, 0, 'hF, 'h3, 1, 'hA0A0A0A0, 0, 'h10,  0);
        vt[3]  = mk(0, 0, 'h0,   'h0,   'h0, 'h0,        0, 0, 'h0, 'h0, 0, 'hB1B1B1B1, 1, 'h20,  0);
        vt[4]  = mk(1, 1, 'h30,  'h40,  'h3, 'h4,        1, 0, 'h1, 'hF, 0, 'hC2C2C2C2, 0, 'h30,  1);
        vt[5]  = mk(0, 0, 'h0,   'h0,   'h0, 'h0,        0, 0, 'h0, 'h0, 3, 'hD3D3D3D3, 1, 'h40,  0);
        vt[6]  = mk(1, 1, 'h50,  'h60,  'h5, 'h6,        0, 1, 'hF, 'h2, 1, 'hE4E4E4E4, 0, 'h50,  0);
        vt[7]  = mk(0, 0, 'h0,   'h0,   'h0, 'h0,        0, 0, 'h0, 'h0, 0, 'hF5F5F5F5, 1, 'h60,  1);
        vt[8]  = mk(0, 1, 'h0,   'h70,  'h0, 'h7,        0, 0, 'h0, 'hF, 0, 'h01010101, 1, 'h70,  0);
        vt[9]  = mk(0, 1, 'h0,   'h80,  'h0, 'h8,        0, 1, 'h0, 'h4, 2, 'h02020202, 1, 'h80,  1);
        vt[10] = mk(1, 1, 'h90,  'hA0,  'h9, 'hA,        0, 0, 'hF, 'hF, 0, 'h03030303, 0, 'h90,  0);
        vt[11] = mk(0, 0, 'h0,   'h0,   'h0, 'h0,        0, 0, 'h0, 'h0, 1, 'h04040404, 1, 'hA0,  0);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].r0 && !pend[0]) raise(0, vt[i].a0, vt[i].d0, vt[i].w0, vt[i].l0);
            if (vt[i].r1 && !pend[1]) raise(1, vt[i].a1, vt[i].d1, vt[i].w1, vt[i].l1);
            serve(vt[i].wt, vt[i].sd, o, ga, gw);
            chk($sformatf("vec%0d_owner", i), 64'(o), 64'(vt[i].eo));
            chk($sformatf("vec%0d_addr", i), 64'(ga), 64'(vt[i].ea));
            chk($sformatf("vec%0d_wr", i), 64'(gw), 64'(vt[i].ew));
        end

        // Stray s_ready while idle, and no re-grant of the master just served.
        s_ready = 1'b1;
        s_din   = 'h0BADF00D;
        repeat (2) begin
            @(negedge clk);
            chk("idle_no_grant", 64'(s_valid), 64'(0));
            chk("idle_no_ready", 64'({m1_ready, m0_ready}), 64'(0));
            chk("idle_din_hold", 64'(m1_din), 64'(din_m[1]));
        end
        s_ready = 1'b0;

        // Reset in the middle of a transaction.
        raise(0, 'h300, 'h33, 1'b1, 'hF);
        raise(1, 'h304, 'h44, 1'b0, 'hF);
        n = 0;
        while (s_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_in_bus", 64'(s_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("midrst_s_valid", 64'(s_valid), 64'(0));
        chk("midrst_ready", 64'({m1_ready, m0_ready}), 64'(0));
        @(negedge clk);
        chk("midrst_ready_hold", 64'({m1_ready, m0_ready}), 64'(0));
        m0_valid = 1'b0;
        pend[0] = 1'b0;
        last = 1;
        din_m[0] = '0;
        din_m[1] = '0;
        rst = 1'b0;
        serve(1, 'h5A5A5A5A, o, ga, gw);
        chk("midrst_then_m1", 64'(o), 64'(1));

        // Randomised traffic against the model.
        for (int k = 0; k < 40; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 1) == 1)
                    raise(m, $urandom, $urandom, 1'($urandom_range(0, 1)), LW'($urandom));
            end
            if (!pend[0] && !pend[1])
                raise(int'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), LW'($urandom));
            serve(int'($urandom_range(0, 3)), $urandom, o, ga, gw);
        end
        while (pend[0] || pend[1]) serve(0, $urandom, o, ga, gw);

`ifdef BUS_ARB_TIMEOUT_EN
        raise(0, 'h400, 'h77, 1'b0, 'hF);
        n = 0;
        while (s_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_grant", 64'(s_valid), 64'(1));
        n = 0;
        while (n < 3 * TO) begin
            @(negedge clk);
            n++;
            if (m0_ready) break;
        end
        chk("to_latency", 64'(n), 64'(TO));
        chk("to_pulse", 64'(timeout), 64'(1));
        chk("to_ready", 64'({m1_ready, m0_ready}), 64'(1));
        chk("to_data", 64'(m0_din), 64'({DW{1'b1}}));
        chk("to_s_valid", 64'(s_valid), 64'(0));
        @(negedge clk);
        chk("to_pulse_end", 64'({timeout, m1_ready, m0_ready}), 64'(0));
        @(negedge clk);
        m0_valid = 1'b0;
        pend[0] = 1'b0;
        last = 0;
        din_m[0] = '1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
